// File: rtl/scene_table_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scene_table_ctrl_pkg
// Description : Shared definitions for the scene-table controller. Holds the
//               game-object entry layout (type/x/y/width/height), the table
//               geometry, request opcodes and the controller state encoding.
//               A type field of 0 marks an empty slot; the display scan stops
//               at the first one.
// Revision    : 1.0 - initial release
// ============================================================================
package scene_table_ctrl_pkg;

    // Entry field layout (offset/length in bits)
    localparam int TYPE_OFF = 0;
    localparam int TYPE_LEN = 4;
    localparam int X_OFF    = 4;
    localparam int X_LEN    = 10;
    localparam int Y_OFF    = 14;
    localparam int Y_LEN    = 10;
    localparam int W_OFF    = 24;
    localparam int W_LEN    = 8;
    localparam int H_OFF    = 32;
    localparam int H_LEN    = 8;

    localparam int ENTRYW   = 40;               // bits per table entry
    localparam int SLOTS    = 8;                // table entries
    localparam int SLOTW    = $clog2(SLOTS);    // slot index width
    localparam int CNTW     = SLOTW + 1;        // live-entry count, 0..SLOTS

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_APPEND = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_COMPACT = 2'd2,
        ST_SWAP    = 2'd3
    } state_t;

    // Assemble an entry from its fields.
    function automatic logic [ENTRYW-1:0] make_entry(
        input logic [TYPE_LEN-1:0] typ,
        input logic [X_LEN-1:0]    x,
        input logic [Y_LEN-1:0]    y,
        input logic [W_LEN-1:0]    w,
        input logic [H_LEN-1:0]    h
    );
        logic [ENTRYW-1:0] e;
        e = '0;
        e[TYPE_OFF +: TYPE_LEN] = typ;
        e[X_OFF    +: X_LEN]    = x;
        e[Y_OFF    +: Y_LEN]    = y;
        e[W_OFF    +: W_LEN]    = w;
        e[H_OFF    +: H_LEN]    = h;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scene_table_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scene_table_ctrl_rr_arbiter
// Description : NREQ-wide round-robin arbiter (the controller's rr_arbiter).
//               Grants the first requester at or after the pointer, one-hot.
//               When advance is high and a grant is made, the pointer moves
//               to grantee+1 mod NREQ.
// Ports       : clock, reset (async, active-low), req[NREQ], advance,
//               grant[NREQ] (one-hot, combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module scene_table_ctrl_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0] r_ptr;
    logic [PTRW-1:0] w_next_ptr;

    always_comb begin
        int   pos;
        logic found;
        grant      = '0;
        w_next_ptr = r_ptr;
        found      = 1'b0;
        pos        = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(r_ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req[pos[PTRW-1:0]]) begin
                grant[pos[PTRW-1:0]] = 1'b1;
                w_next_ptr = (pos == NREQ - 1) ? '0 : PTRW'(pos + 1);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance && (|req)) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scene_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scene_table_ctrl
// Description : Owns the game-object table scanned by the display. Requesters
//               submit write/append/delete ops via valid/ready, granted
//               round-robin. Deletes are compacted so the table never has a
//               hole. Optional macro SCENE_TABLE_DBLBUF_EN: updates land in a
//               shadow table copied to gamedata only after frame_sync; when
//               undefined, gamedata shows the shadow table directly.
// Ports       : clock, reset (async, active-low)
//               req_valid/req_op/req_slot/req_data in, req_ready out (per req)
//               frame_sync in; gamedata, count, busy, err out
// Revision    : 1.0 - initial release
// ============================================================================
module scene_table_ctrl
    import scene_table_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [SLOTW*NREQ-1:0]    req_slot,
    input  logic [ENTRYW*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     frame_sync,
    output logic [SLOTS*ENTRYW-1:0]  gamedata,
    output logic [CNTW-1:0]          count,
    output logic                     busy,
    output logic                     err
);

    state_t              r_state;
    logic [ENTRYW-1:0]   r_shadow [SLOTS];
    logic [CNTW-1:0]     r_count;
    logic [SLOTW-1:0]    r_idx;
    logic [1:0]          r_op;
    logic [SLOTW-1:0]    r_slot;
    logic [ENTRYW-1:0]   r_data;

    logic [NREQ-1:0]     w_grant;
    logic                w_arb_en;
    logic [1:0]          w_sel_op;
    logic [SLOTW-1:0]    w_sel_slot;
    logic [ENTRYW-1:0]   w_sel_data;
    logic                w_type_nz;
    logic                w_slot_ok;
    logic                w_write_ok;
    logic                w_append_ok;
    logic                w_delete_ok;
    logic                w_shift;

`ifdef SCENE_TABLE_DBLBUF_EN
    logic                r_swap_pend;
    logic [ENTRYW-1:0]   r_active [SLOTS];
    // A pending swap blocks new grants so the copy sees a settled table.
    assign w_arb_en = (r_state == ST_IDLE) && !r_swap_pend;
`else
    logic                w_unused_frame_sync;
    assign w_unused_frame_sync = frame_sync;
    assign w_arb_en = (r_state == ST_IDLE);
`endif

    scene_table_ctrl_rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_arb_en),
        .grant   (w_grant)
    );

    assign req_ready = w_grant & {NREQ{w_arb_en}};

    // One-hot grant selects the grantee's request fields.
    always_comb begin
        w_sel_op   = '0;
        w_sel_slot = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op   = req_op[i*2 +: 2];
                w_sel_slot = req_slot[i*SLOTW +: SLOTW];
                w_sel_data = req_data[i*ENTRYW +: ENTRYW];
            end
        end
    end

    assign w_type_nz   = (r_data[TYPE_OFF +: TYPE_LEN] != '0);
    assign w_slot_ok   = (CNTW'(r_slot) < r_count);
    assign w_write_ok  = (r_op == OP_WRITE)  && w_slot_ok && w_type_nz;
    assign w_append_ok = (r_op == OP_APPEND) && (r_count < CNTW'(SLOTS)) && w_type_nz;
    assign w_delete_ok = (r_op == OP_DELETE) && w_slot_ok;
    // Keep shifting down while the slot above the cursor is still live.
    assign w_shift     = ((CNTW'(r_idx) + CNTW'(1)) < r_count);

    assign err   = (r_state == ST_EXEC) && !(w_write_ok || w_append_ok || w_delete_ok);
    assign busy  = (r_state != ST_IDLE);
    assign count = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_op    <= '0;
            r_slot  <= '0;
            r_data  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_shadow[i] <= '0;
            end
`ifdef SCENE_TABLE_DBLBUF_EN
            r_swap_pend <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_active[i] <= '0;
            end
`endif
        end else begin
`ifdef SCENE_TABLE_DBLBUF_EN
            // A frame_sync landing while a swap is pending merges into it.
            if (r_state == ST_SWAP) begin
                r_swap_pend <= 1'b0;
            end else if (frame_sync) begin
                r_swap_pend <= 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: begin
`ifdef SCENE_TABLE_DBLBUF_EN
                    if (r_swap_pend) begin
                        r_state <= ST_SWAP;
                    end else
`endif
                    if (|req_valid) begin
                        r_op    <= w_sel_op;
                        r_slot  <= w_sel_slot;
                        r_data  <= w_sel_data;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    if (w_write_ok) begin
                        r_shadow[r_slot] <= r_data;
                    end else if (w_append_ok) begin
                        r_shadow[r_count[SLOTW-1:0]] <= r_data;
                        r_count <= r_count + CNTW'(1);
                    end else if (w_delete_ok) begin
                        r_idx   <= r_slot;
                        r_state <= ST_COMPACT;
                    end
                end
                ST_COMPACT: begin
                    if (w_shift) begin
                        r_shadow[r_idx] <= r_shadow[r_idx + SLOTW'(1)];
                        r_idx           <= r_idx + SLOTW'(1);
                    end else begin
                        r_shadow[SLOTW'(r_count - CNTW'(1))] <= '0;
                        r_count <= r_count - CNTW'(1);
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWAP: begin
`ifdef SCENE_TABLE_DBLBUF_EN
                    for (int i = 0; i < SLOTS; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_pack
`ifdef SCENE_TABLE_DBLBUF_EN
        assign gamedata[g*ENTRYW +: ENTRYW] = r_active[g];
`else
        assign gamedata[g*ENTRYW +: ENTRYW] = r_shadow[g];
`endif
    end

endmodule
`default_nettype wire
